ram_bist_ctrl: RTL and testbench

- March C- memory BIST controller and access arbiter for the 128x16 test-wrapped RAM in the flash_bounder datapath.
- While idle, the functional port passes through to the RAM.
- On a start pulse, the block takes ownership of the RAM, runs the march algorithm and reports pass/fail with first-failure diagnostics.
- Sits between the functional logic and the RAM wrapper.

---
 rtl/ram_bist_pkg.sv | 30 +++
 rtl/ram_bist_addr_gen.sv | 27 ++
 rtl/ram_bist_ctrl.sv | 164 ++++++++++++++++
 tb/tb_ram_bist_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_bist_pkg.sv
// Shared types for the March C- RAM BIST controller: FSM states, element
// codes and the per-element march table.
package ram_bist_pkg;

   typedef enum logic [2:0] {IDLE, RD, WAIT, CMP, WR, DONE, FAIL} state_t;
   typedef enum logic [2:0] {M0, M1, M2, M3, M4, M5} elem_t;

   typedef struct packed {
      logic down;     // sweep 127 -> 0
      logic rd_pol;   // expected read value: 0 = BG, 1 = ~BG
      logic wr_pol;   // written value: 0 = BG, 1 = ~BG
      logic has_rd;
      logic has_wr;
   } elem_cfg_t;

   localparam elem_t LAST_ELEM = M5;

   // Indexed by element code; entries 6 and 7 are unused padding.
   localparam elem_cfg_t ELEM_TAB [8] = '{
      '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1},   // M0 up   (w0)
      '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1},   // M1 up   (r0,w1)
      '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1},   // M2 up   (r1,w0)
      '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1},   // M3 down (r0,w1)
      '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1},   // M4 down (r1,w0)
      '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0},   // M5 up   (r0)
      '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
      '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0}
   };

endpackage

// File: rtl/ram_bist_addr_gen.sv
// Loadable up/down address counter for the march sweeps; last flags the
// terminal address of the current direction.
module ram_bist_addr_gen #(
   parameter int ADDR_W = 7
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              load_down,
   input  logic              step,
   input  logic              down,
   output logic [ADDR_W-1:0] addr,
   output logic              last
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         addr <= '0;
      else if (load)
         addr <= load_down ? '1 : '0;
      else if (step)
         addr <= down ? addr - ADDR_W'(1) : addr + ADDR_W'(1);
   end

   assign last = down ? (addr == '0) : (addr == '1);

endmodule

// File: rtl/ram_bist_ctrl.sv
// March C- BIST controller and RAM access arbiter: functional port passes
// through while idle, BIST registers own the RAM while busy.
module ram_bist_ctrl
   import ram_bist_pkg::*;
#(
   parameter int                ADDR_W = 7,
   parameter int                DATA_W = 16,
   parameter int                RD_LAT = 1,
   parameter logic [DATA_W-1:0] BG     = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              bist_start,
   output logic              bist_busy,
   output logic              bist_done,
   output logic              bist_pass,
   output logic [ADDR_W-1:0] fail_addr,
   output logic [2:0]        fail_elem,
   output logic [DATA_W-1:0] fail_data,
   input  logic [ADDR_W-1:0] func_a,
   input  logic [DATA_W-1:0] func_din,
   input  logic              func_wr,
   input  logic              func_oe,
   input  logic              func_test_mode,
   output logic [DATA_W-1:0] func_dout,
   output logic [ADDR_W-1:0] ram_a,
   output logic [DATA_W-1:0] ram_din,
   output logic              ram_wr,
   output logic              ram_oe,
   output logic              ram_test_mode,
   input  logic [DATA_W-1:0] ram_dout
);

   state_t            state;
   elem_t             elem;
   logic [1:0]        wait_cnt;
   logic              oe_r, wr_r;
   logic [DATA_W-1:0] din_r;
   logic [ADDR_W-1:0] addr;
   logic              last;

   logic              start_ok, mismatch, adv, seq_end;
   logic              ag_load, ag_load_down, ag_step;
   logic [2:0]        nxt_idx;
   logic [DATA_W-1:0] rd_exp;

   function automatic logic [DATA_W-1:0] word(input logic pol);
      return pol ? ~BG : BG;
   endfunction

   always_comb begin
      start_ok     = bist_start && (state == IDLE || state == DONE || state == FAIL);
      rd_exp       = word(ELEM_TAB[elem].rd_pol);
      mismatch     = (state == CMP) && ELEM_TAB[elem].has_rd && (ram_dout != rd_exp);
      adv          = (state == WR) ||
                     (state == CMP && !ELEM_TAB[elem].has_wr && !mismatch);
      seq_end      = adv && last && (elem == LAST_ELEM);
      nxt_idx      = last ? 3'(elem) + 3'd1 : 3'(elem);
      ag_load      = start_ok || (adv && last && !seq_end);
      ag_load_down = start_ok ? 1'b0 : ELEM_TAB[nxt_idx].down;
      ag_step      = adv && !last;
   end

   ram_bist_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (ag_load),
      .load_down (ag_load_down),
      .step      (ag_step),
      .down      (ELEM_TAB[elem].down),
      .addr      (addr),
      .last      (last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         elem      <= M0;
         wait_cnt  <= '0;
         oe_r      <= 1'b0;
         wr_r      <= 1'b0;
         din_r     <= '0;
         bist_busy <= 1'b0;
         bist_done <= 1'b0;
         bist_pass <= 1'b0;
         fail_addr <= '0;
         fail_elem <= '0;
         fail_data <= '0;
      end else if (start_ok) begin
         bist_busy <= 1'b1;
         bist_done <= 1'b0;
         bist_pass <= 1'b0;
         fail_addr <= '0;
         fail_elem <= '0;
         fail_data <= '0;
         elem      <= M0;
         state     <= WR;
         oe_r      <= 1'b0;
         wr_r      <= 1'b1;
         din_r     <= word(ELEM_TAB[M0].wr_pol);
      end else if (adv) begin
         // Address finished: step, move to the next element, or complete.
         wr_r <= 1'b0;
         elem <= elem_t'(nxt_idx);
         if (seq_end) begin
            state     <= DONE;
            oe_r      <= 1'b0;
            bist_busy <= 1'b0;
            bist_done <= 1'b1;
            bist_pass <= 1'b1;
         end else if (ELEM_TAB[nxt_idx].has_rd) begin
            state <= RD;
            oe_r  <= 1'b1;
         end else begin
            state <= WR;
            oe_r  <= 1'b0;
            wr_r  <= 1'b1;
            din_r <= word(ELEM_TAB[nxt_idx].wr_pol);
         end
      end else begin
         case (state)
            RD: begin
               if (RD_LAT > 1) begin
                  state    <= WAIT;
                  wait_cnt <= 2'(RD_LAT - 2);
               end else begin
                  state <= CMP;
               end
            end
            WAIT: begin
               if (wait_cnt == '0) state <= CMP;
               else                wait_cnt <= wait_cnt - 2'd1;
            end
            CMP: begin
               if (mismatch) begin
                  // First failure stops the run; the pending write is dropped.
                  state     <= FAIL;
                  oe_r      <= 1'b0;
                  bist_busy <= 1'b0;
                  bist_done <= 1'b1;
                  bist_pass <= 1'b0;
                  fail_addr <= addr;
                  fail_elem <= elem;
                  fail_data <= ram_dout;
               end else begin
                  state <= WR;
                  oe_r  <= 1'b0;
                  wr_r  <= 1'b1;
                  din_r <= word(ELEM_TAB[elem].wr_pol);
               end
            end
            default: ;
         endcase
      end
   end

   assign ram_a         = bist_busy ? addr  : func_a;
   assign ram_din       = bist_busy ? din_r : func_din;
   assign ram_wr        = bist_busy ? wr_r  : func_wr;
   assign ram_oe        = bist_busy ? oe_r  : func_oe;
   assign ram_test_mode = bist_busy ? 1'b0  : func_test_mode;
   assign func_dout     = ram_dout;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Directed bench for ram_bist_ctrl: behavioural RAMs with optional planted
// faults, one instance at RD_LAT=1/BG=0 and one at RD_LAT=2/BG=AAAA.
module tb_ram_bist_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        bist_start, bist_start_b;
   logic [6:0]  func_a;
   logic [15:0] func_din;
   logic        func_wr, func_oe, func_test_mode;

   logic        bist_busy, bist_done, bist_pass;
   logic [6:0]  fail_addr;
   logic [2:0]  fail_elem;
   logic [15:0] fail_data, func_dout;
   logic [6:0]  ram_a;
   logic [15:0] ram_din, ram_dout;
   logic        ram_wr, ram_oe, ram_test_mode;

   logic        busy_b, done_b, pass_b;
   logic [6:0]  fail_addr_b;
   logic [2:0]  fail_elem_b;
   logic [15:0] fail_data_b, func_dout_b;
   logic [6:0]  ram_a_b;
   logic [15:0] ram_din_b, ram_dout_b;
   logic        ram_wr_b, ram_oe_b, ram_test_mode_b;

   ram_bist_ctrl #(.ADDR_W(7), .DATA_W(16), .RD_LAT(1), .BG(16'h0000)) dut (
      .clk(clk), .rst_n(rst_n), .bist_start(bist_start),
      .bist_busy(bist_busy), .bist_done(bist_done), .bist_pass(bist_pass),
      .fail_addr(fail_addr), .fail_elem(fail_elem), .fail_data(fail_data),
      .func_a(func_a), .func_din(func_din), .func_wr(func_wr), .func_oe(func_oe),
      .func_test_mode(func_test_mode), .func_dout(func_dout),
      .ram_a(ram_a), .ram_din(ram_din), .ram_wr(ram_wr), .ram_oe(ram_oe),
      .ram_test_mode(ram_test_mode), .ram_dout(ram_dout)
   );

   ram_bist_ctrl #(.ADDR_W(7), .DATA_W(16), .RD_LAT(2), .BG(16'hAAAA)) dut_b (
      .clk(clk), .rst_n(rst_n), .bist_start(bist_start_b),
      .bist_busy(busy_b), .bist_done(done_b), .bist_pass(pass_b),
      .fail_addr(fail_addr_b), .fail_elem(fail_elem_b), .fail_data(fail_data_b),
      .func_a(func_a), .func_din(func_din), .func_wr(func_wr), .func_oe(func_oe),
      .func_test_mode(func_test_mode), .func_dout(func_dout_b),
      .ram_a(ram_a_b), .ram_din(ram_din_b), .ram_wr(ram_wr_b), .ram_oe(ram_oe_b),
      .ram_test_mode(ram_test_mode_b), .ram_dout(ram_dout_b)
   );

   // RAM A: one-cycle read; fault_mode 1 = bit 3 stuck-at-1 at 0x2A,
   // fault_mode 2 = writing bit0=1 to 0x11 forces bit0 of 0x10 to 1.
   int          fault_mode = 0;
   logic [15:0] mem_a [128];
   logic [15:0] rd_a;
   always @(posedge clk) begin
      if (ram_wr) begin
         mem_a[ram_a] <= ram_din;
         if (fault_mode == 2 && ram_a == 7'h11 && ram_din[0])
            mem_a[7'h10][0] <= 1'b1;
      end
      if (ram_oe)
         rd_a <= (fault_mode == 1 && ram_a == 7'h2A) ? (mem_a[ram_a] | 16'h0008)
                                                      : mem_a[ram_a];
   end
   assign ram_dout = rd_a;

   // RAM B: fault-free, two-cycle read.
   logic [15:0] mem_b [128];
   logic [15:0] rd_b0, rd_b1;
   always @(posedge clk) begin
      if (ram_wr_b) mem_b[ram_a_b] <= ram_din_b;
      if (ram_oe_b) rd_b0 <= mem_b[ram_a_b];
      rd_b1 <= rd_b0;
   end
   assign ram_dout_b = rd_b1;

   int busy_cnt = 0, wr_cnt = 0, tm_bad = 0, ovl_bad = 0;
   int busy_cnt_b = 0, wr55_b = 0, wraa_b = 0, wrbad_b = 0;
   always @(negedge clk) begin
      if (bist_busy) begin
         busy_cnt <= busy_cnt + 1;
         if (ram_wr)           wr_cnt  <= wr_cnt + 1;
         if (ram_test_mode)    tm_bad  <= tm_bad + 1;
         if (ram_wr && ram_oe) ovl_bad <= ovl_bad + 1;
      end
      if (busy_b) begin
         busy_cnt_b <= busy_cnt_b + 1;
         if (ram_wr_b) begin
            if (ram_din_b == 16'h5555)      wr55_b  <= wr55_b + 1;
            else if (ram_din_b == 16'hAAAA) wraa_b  <= wraa_b + 1;
            else                            wrbad_b <= wrbad_b + 1;
         end
      end
   end

   int total = 0, bad = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Leaves the bench one #1 into cycle 1 (start sampled at edge 0).
   task automatic pulse_start();
      bist_start = 1'b1;
      step();
      bist_start = 1'b0;
   endtask

   task automatic run_to_done(input int limit, output int cyc);
      cyc = 1;
      while (!bist_done && cyc < limit) begin
         step();
         cyc++;
      end
   endtask

   int cyc;
   int b_busy, b_wr, b_tm, b_ovl;

   initial begin
      rst_n = 1'b0; bist_start = 1'b0; bist_start_b = 1'b0;
      func_a = '0; func_din = '0; func_wr = 1'b0; func_oe = 1'b0; func_test_mode = 1'b0;
      repeat (3) step();
      check("rst_busy", bist_busy, 1'b0);
      check("rst_done", bist_done, 1'b0);
      check("rst_pass", bist_pass, 1'b0);
      check("rst_fail_addr", fail_addr, 7'h00);
      check("rst_fail_elem", fail_elem, 3'd0);
      check("rst_fail_data", fail_data, 16'h0000);
      rst_n = 1'b1;
      step();

      // Fault-free run with a re-pulse at cycle 500 and functional noise.
      fault_mode = 0;
      b_busy = busy_cnt; b_wr = wr_cnt; b_tm = tm_bad; b_ovl = ovl_bad;
      pulse_start();
      func_a = 7'h33; func_din = 16'h1234; func_wr = 1'b1; func_oe = 1'b1; func_test_mode = 1'b1;
      #1;
      check("c1_busy", bist_busy, 1'b1);
      check("c1_ram_wr", ram_wr, 1'b1);
      check("c1_ram_oe", ram_oe, 1'b0);
      check("c1_ram_a", ram_a, 7'h00);
      check("c1_ram_din", ram_din, 16'h0000);
      check("c1_test_mode", ram_test_mode, 1'b0);
      cyc = 1;
      while (!bist_done && cyc < 4000) begin
         bist_start = (cyc == 500);
         step();
         cyc++;
      end
      bist_start = 1'b0;
      func_wr = 1'b0; func_oe = 1'b0; func_test_mode = 1'b0;
      check("run1_done_cycle", cyc, 1921);
      check("run1_done", bist_done, 1'b1);
      check("run1_pass", bist_pass, 1'b1);
      check("run1_busy", bist_busy, 1'b0);
      check("run1_busy_cycles", busy_cnt - b_busy, 1920);
      check("run1_wr_pulses", wr_cnt - b_wr, 640);
      check("run1_test_mode_busy", tm_bad - b_tm, 0);
      check("run1_wr_oe_overlap", ovl_bad - b_ovl, 0);

      // Functional pass-through after completion.
      func_a = 7'h05; func_din = 16'hBEEF; func_wr = 1'b1; func_test_mode = 1'b1;
      #1;
      check("pt_ram_a", ram_a, 7'h05);
      check("pt_ram_din", ram_din, 16'hBEEF);
      check("pt_ram_wr", ram_wr, 1'b1);
      check("pt_test_mode", ram_test_mode, 1'b1);
      step();
      func_wr = 1'b0; func_oe = 1'b1; func_test_mode = 1'b0;
      step();
      check("pt_func_dout", func_dout, 16'hBEEF);
      func_oe = 1'b0;
      step();

      // Stuck-at-1 on bit 3 of 0x2A: caught by the first read of M1.
      fault_mode = 1;
      b_wr = wr_cnt;
      pulse_start();
      check("sa_done_cleared", bist_done, 1'b0);
      run_to_done(4000, cyc);
      check("sa_fail_cycle", cyc, 257);
      check("sa_pass", bist_pass, 1'b0);
      check("sa_fail_elem", fail_elem, 3'd1);
      check("sa_fail_addr", fail_addr, 7'h2A);
      check("sa_fail_data", fail_data, 16'h0008);
      check("sa_wr_pulses", wr_cnt - b_wr, 170);
      repeat (5) step();
      check("sa_no_wr_after", wr_cnt - b_wr, 170);

      // Coupling 0x11 -> 0x10: only seen by the descending M3 sweep.
      fault_mode = 2;
      b_wr = wr_cnt;
      pulse_start();
      check("cf_fail_addr_cleared", fail_addr, 7'h00);
      check("cf_fail_elem_cleared", fail_elem, 3'd0);
      check("cf_fail_data_cleared", fail_data, 16'h0000);
      run_to_done(4000, cyc);
      check("cf_fail_cycle", cyc, 1232);
      check("cf_pass", bist_pass, 1'b0);
      check("cf_fail_elem", fail_elem, 3'd3);
      check("cf_fail_addr", fail_addr, 7'h10);
      check("cf_fail_data", fail_data, 16'h0001);
      check("cf_wr_pulses", wr_cnt - b_wr, 495);

      // Reset in the middle of a run, then a fresh run.
      fault_mode = 0;
      pulse_start();
      cyc = 1;
      while (cyc < 700) begin
         step();
         cyc++;
      end
      func_a = 7'h44; func_din = 16'h0F0F; func_wr = 1'b0; func_oe = 1'b1; func_test_mode = 1'b1;
      rst_n = 1'b0;
      #1;
      check("mr_busy", bist_busy, 1'b0);
      check("mr_done", bist_done, 1'b0);
      check("mr_pass", bist_pass, 1'b0);
      check("mr_ram_a", ram_a, 7'h44);
      check("mr_ram_din", ram_din, 16'h0F0F);
      check("mr_ram_oe", ram_oe, 1'b1);
      check("mr_test_mode", ram_test_mode, 1'b1);
      step();
      rst_n = 1'b1;
      func_oe = 1'b0; func_test_mode = 1'b0;
      step();
      pulse_start();
      run_to_done(4000, cyc);
      check("mr_rerun_cycle", cyc, 1921);
      check("mr_rerun_pass", bist_pass, 1'b1);

      // RD_LAT=2, BG=AAAA: one extra wait cycle per read, 640 reads.
      b_busy = busy_cnt_b;
      bist_start_b = 1'b1;
      step();
      bist_start_b = 1'b0;
      cyc = 1;
      while (!done_b && cyc < 6000) begin
         step();
         cyc++;
      end
      check("b_done_cycle", cyc, 2561);
      check("b_busy_cycles", busy_cnt_b - b_busy, 2560);
      check("b_pass", pass_b, 1'b1);
      check("b_wr_5555", wr55_b, 256);
      check("b_wr_aaaa", wraa_b, 384);
      check("b_wr_other", wrbad_b, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
